// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op bit positions, FSM state encoding and a one-hot qualifier.
package mdu_pkg;

    localparam int MDU_MULT  = 3;
    localparam int MDU_MULTU = 2;
    localparam int MDU_DIV   = 1;
    localparam int MDU_DIVU  = 0;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mdu_state_t;

    // Zero and multi-hot op codes are not requests.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the
// divisor when it fits, and report the resulting quotient bit.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    assign trial = {rem_i, bit_i};
    assign diff  = trial - {1'b0, divisor_i};
    assign q_o   = (trial >= {1'b0, divisor_i});
    // Either branch is below the divisor, so WIDTH bits always suffice.
    assign rem_o = q_o ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Iterative MIPS mult/multu/div/divu unit: one bit per cycle on operand
// magnitudes, sign fix-up on the final edge, result held until taken.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] scr0,
    input  logic [WIDTH-1:0] scr1,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mdu_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q, sh_q, opnd_q, hi_q, lo_q;
    logic             is_div_q, dz_q, neg_lo_q, neg_hi_q;

    logic             accept, signed_op, div_op, div_zero, s0, s1, q_bit;
    logic [WIDTH-1:0] mag0, mag1, rem_nx, mul_add, lo_fix, hi_fix;
    logic [WIDTH:0]   msum;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign accept    = in_valid && (state_q == IDLE) && !flush && is_onehot4(op);
    assign signed_op = op[MDU_MULT] | op[MDU_DIV];
    assign div_op    = op[MDU_DIV] | op[MDU_DIVU];
    assign div_zero  = div_op && (scr1 == '0);
    assign s0        = signed_op & scr0[WIDTH-1];
    assign s1        = signed_op & scr1[WIDTH-1];
    assign mag0      = s0 ? -scr0 : scr0;
    assign mag1      = s1 ? -scr1 : scr1;

    // Multiply: acc_q is the running upper half, sh_q the multiplier
    // shifting out LSB-first while product bits shift in from the top.
    assign mul_add = sh_q[0] ? opnd_q : '0;
    assign msum    = {1'b0, acc_q} + {1'b0, mul_add};

    // Divide: acc_q is the partial remainder, sh_q the dividend shifting
    // out MSB-first while quotient bits shift in at the bottom.
    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (acc_q),
        .bit_i     (sh_q[WIDTH-1]),
        .divisor_i (opnd_q),
        .rem_o     (rem_nx),
        .q_o       (q_bit)
    );

    assign prod     = {acc_q, sh_q};
    assign prod_fix = neg_lo_q ? -prod : prod;
    assign lo_fix   = neg_lo_q ? -sh_q : sh_q;
    assign hi_fix   = neg_hi_q ? -acc_q : acc_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q  <= CALC;
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        is_div_q <= div_op;
                        dz_q     <= div_zero;
                        neg_lo_q <= s0 ^ s1;
                        neg_hi_q <= div_op ? s0 : (s0 ^ s1);
                        opnd_q   <= div_op ? mag1 : mag0;
                        // Divide-by-zero returns the raw dividend in hi.
                        sh_q     <= div_zero ? scr0 : (div_op ? mag0 : mag1);
                    end
                end
                CALC: begin
                    if (dz_q) begin
                        state_q <= DONE;
                        hi_q    <= sh_q;
                        lo_q    <= '1;
                    end else if (cnt_q == CNT_W'(WIDTH)) begin
                        state_q <= DONE;
                        if (is_div_q) begin
                            hi_q <= hi_fix;
                            lo_q <= lo_fix;
                        end else begin
                            {hi_q, lo_q} <= prod_fix;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (is_div_q) begin
                            acc_q <= rem_nx;
                            sh_q  <= {sh_q[WIDTH-2:0], q_bit};
                        end else begin
                            {acc_q, sh_q} <= {msum, sh_q[WIDTH-1:1]};
                        end
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: reference results are queued at issue
// time and compared when out_valid is seen.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [31:0] scr0 = '0;
    logic [31:0] scr1 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] hi, lo;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t sb[$];
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    mdu_iter #(.WIDTH(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .scr0      (scr0),
        .scr1      (scr1),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb_, p;
        longint unsigned up;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        e.lat = 33;
        if (o == 4'b1000) begin
            p = sa * sb_;
            {e.hi, e.lo} = p;
        end else if (o == 4'b0100) begin
            up = {32'd0, a} * {32'd0, b};
            {e.hi, e.lo} = up;
        end else if (b == 32'd0) begin
            e.lo = 32'hFFFF_FFFF;
            e.hi = a;
            e.lat = 1;
        end else if (o == 4'b0010) begin
            e.lo = 32'(sa / sb_);
            e.hi = 32'(sa % sb_);
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    // Drives one request from a negedge; returns at the negedge after accept.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        op = o;
        scr0 = a;
        scr1 = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op = 4'($urandom);
        scr0 = $urandom;
        scr1 = $urandom;
        sb.push_back(model(o, a, b));
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset: out_valid=%b busy=%b hi=%h lo=%h, want 0 0 0 0", out_valid, busy, hi, lo);
        end
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b busy=%b, want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_multu_full;
        int cyc;
        exp_t e;
        out_ready = 1'b1;
        issue(4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_out(cyc);
        e = sb.pop_front();
        checks++;
        if (cyc != e.lat) begin
            errors++;
            $display("FAIL multu_latency: got %0d edges, want %0d", cyc, e.lat);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu_result: hi=%h lo=%h, want hi=fffffffe lo=00000001", hi, lo);
        end
        last_hi = e.hi;
        last_lo = e.lo;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL multu_handshake: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_signed_ops;
        logic [3:0]  ops [4] = '{4'b1000, 4'b0001, 4'b0010, 4'b0010};
        logic [31:0] as  [4] = '{32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'd5, 32'd2, 32'd2, 32'hFFFF_FFFF};
        logic [31:0] eh  [4] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] el  [4] = '{32'hFFFF_FFF1, 32'd3, 32'hFFFF_FFFD, 32'h8000_0000};
        int cyc;
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_out(cyc);
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || cyc != e.lat || hi !== eh[i] || lo !== el[i]) begin
                errors++;
                $display("FAIL signed_op%0d: valid=%b lat=%0d hi=%h lo=%h, want 1 %0d hi=%h lo=%h",
                         i, out_valid, cyc, hi, lo, e.lat, eh[i], el[i]);
            end
            last_hi = eh[i];
            last_lo = el[i];
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_divzero;
        int cyc;
        exp_t e;
        out_ready = 1'b1;
        issue(4'b0001, 32'h0000_1234, 32'd0);
        checks++;
        if (hi !== last_hi || lo !== last_lo) begin
            errors++;
            $display("FAIL divzero_hold: hi=%h lo=%h before done, want %h %h", hi, lo, last_hi, last_lo);
        end
        wait_out(cyc);
        e = sb.pop_front();
        checks++;
        if (cyc != 1 || hi !== 32'h0000_1234 || lo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL divzero: lat=%0d hi=%h lo=%h, want 1 hi=00001234 lo=ffffffff", cyc, hi, lo);
        end
        last_hi = e.hi;
        last_lo = e.lo;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_flush;
        int cyc;
        int bad;
        exp_t e;
        out_ready = 1'b1;
        issue(4'b1000, 32'h1234_5678, 32'h9ABC_DEF0);
        void'(sb.pop_back());
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b1 || hi !== last_hi) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL flush_calc: %0d bad cycles during CALC, want 0", bad);
        end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || hi !== last_hi || lo !== last_lo) begin
            errors++;
            $display("FAIL flush_abort: in_ready=%b busy=%b valid=%b hi=%h lo=%h, want 1 0 0 %h %h",
                     in_ready, busy, out_valid, hi, lo, last_hi, last_lo);
        end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL flush_no_result: out_valid high %0d cycles, want 0", bad);
        end
        in_valid = 1'b1;
        op = 4'b0100;
        scr0 = 32'd9;
        scr1 = 32'd9;
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_priority: busy=%b, want 0", busy);
        end
        issue(4'b0100, 32'd2, 32'd3);
        wait_out(cyc);
        e = sb.pop_front();
        checks++;
        if (cyc != e.lat || hi !== 32'd0 || lo !== 32'd6) begin
            errors++;
            $display("FAIL flush_recover: lat=%0d hi=%h lo=%h, want %0d hi=0 lo=6", cyc, hi, lo, e.lat);
        end
        last_hi = e.hi;
        last_lo = e.lo;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_stall_illegal;
        int cyc;
        int bad;
        exp_t e;
        out_ready = 1'b0;
        issue(4'b0001, 32'd100, 32'd7);
        wait_out(cyc);
        e = sb.pop_front();
        checks++;
        if (cyc != e.lat || hi !== 32'd2 || lo !== 32'd14) begin
            errors++;
            $display("FAIL stall_result: lat=%0d hi=%h lo=%h, want %0d hi=2 lo=14", cyc, hi, lo, e.lat);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b1 || hi !== 32'd2 || lo !== 32'd14) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: %0d cycles changed while stalled, want 0", bad);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        bad = 0;
        in_valid = 1'b1;
        scr0 = 32'd5;
        scr1 = 32'd5;
        for (int i = 0; i < 4; i++) begin
            op = (i < 2) ? 4'b0110 : 4'b0000;
            @(posedge clk);
            @(negedge clk);
            if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL illegal_op: %0d cycles showed an accept, want 0", bad);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        exp_t e;
        logic [3:0]  o;
        logic [31:0] a, b;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            o = 4'b0001 << $urandom_range(0, 3);
            a = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 28);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready%0d: in_ready=%b, want 1", i, in_ready);
            end
            issue(o, a, b);
            wait_out(cyc);
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || cyc != e.lat || hi !== e.hi || lo !== e.lo) begin
                errors++;
                $display("FAIL b2b_op%0d op=%b a=%h b=%h: lat=%0d hi=%h lo=%h, want %0d hi=%h lo=%h",
                         i, o, a, b, cyc, hi, lo, e.lat, e.hi, e.lo);
                if (out_valid !== 1'b1) begin
                    flush = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    flush = 1'b0;
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_multu_full();
        test_signed_ops();
        test_divzero();
        test_flush();
        test_stall_illegal();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
